// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the OpenMIPS single-port memory bus arbiter.
// Holds the FSM state encoding, the ctrl stall-vector bit positions and the bus field bundle.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_DBUSY  = 2'd1,
    ARB_IBUSY  = 2'd2,
    ARB_IFLUSH = 2'd3
  } arb_state_e;

  // Positions inside the ctrl stall vector.
  localparam int unsigned STALL_IFID = 1;
  localparam int unsigned STALL_MEM  = 4;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_fields_t;

  function automatic bus_fields_t fetch_fields(input logic [31:0] addr);
    bus_fields_t f;
    f.we    = 1'b0;
    f.sel   = 4'hF;
    f.addr  = addr;
    f.wdata = 32'h0;
    return f;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one registered req/ack memory bus between instruction fetch and data access.
// Data side has priority; fetches can be flushed, and results are buffered across stalls.
module sram_arbiter
  import sram_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_stallreq_o,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  arb_state_e  state_q, state_d;
  bus_fields_t bus_q, bus_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] dbuf_q, dbuf_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic        dbuf_valid_q, dbuf_valid_d;
  logic        ibuf_valid_q, ibuf_valid_d;

  logic        d_ack, i_ack;
  logic        d_pend, i_pend;
  bus_fields_t mem_fields;
  logic        unused_stall;

  assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  assign d_ack  = (state_q == ARB_DBUSY) & bus_ack_i;
  assign i_ack  = (state_q == ARB_IBUSY) & bus_ack_i;
  assign d_pend = mem_ce_i & ~dbuf_valid_q;
  assign i_pend = if_ce_i & ~ibuf_valid_q & ~flush_i;

  assign mem_fields.we    = mem_we_i;
  assign mem_fields.sel   = mem_sel_i;
  assign mem_fields.addr  = mem_addr_i;
  assign mem_fields.wdata = mem_wdata_i;

  always_comb begin
    state_d      = state_q;
    bus_d        = bus_q;
    bus_req_d    = bus_req_q;
    dbuf_d       = dbuf_q;
    ibuf_d       = ibuf_q;
    // Buffered results live only as long as the consuming stage is held.
    dbuf_valid_d = dbuf_valid_q & stall_i[STALL_MEM];
    ibuf_valid_d = ibuf_valid_q & stall_i[STALL_IFID] & ~flush_i;

    case (state_q)
      ARB_IDLE: begin
        if (d_pend) begin
          state_d   = ARB_DBUSY;
          bus_req_d = 1'b1;
          bus_d     = mem_fields;
        end else if (i_pend) begin
          state_d   = ARB_IBUSY;
          bus_req_d = 1'b1;
          bus_d     = fetch_fields(if_addr_i);
        end
      end

      ARB_DBUSY: begin
        if (bus_ack_i) begin
          dbuf_d       = bus_rdata_i;
          dbuf_valid_d = 1'b1;
          if (i_pend) begin
            state_d = ARB_IBUSY;
            bus_d   = fetch_fields(if_addr_i);
          end else begin
            state_d   = ARB_IDLE;
            bus_req_d = 1'b0;
          end
        end
      end

      ARB_IBUSY: begin
        if (bus_ack_i && flush_i) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
        end else if (bus_ack_i) begin
          ibuf_d       = bus_rdata_i;
          ibuf_valid_d = 1'b1;
          if (d_pend) begin
            state_d = ARB_DBUSY;
            bus_d   = mem_fields;
          end else begin
            state_d   = ARB_IDLE;
            bus_req_d = 1'b0;
          end
        end else if (flush_i) begin
          // The slave cannot be aborted, so ride out the ack and drop it.
          state_d = ARB_IFLUSH;
        end
      end

      ARB_IFLUSH: begin
        if (bus_ack_i) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
        end
      end

      default: begin
        state_d   = ARB_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      bus_q        <= '0;
      bus_req_q    <= 1'b0;
      dbuf_q       <= 32'h0;
      ibuf_q       <= 32'h0;
      dbuf_valid_q <= 1'b0;
      ibuf_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_q        <= bus_d;
      bus_req_q    <= bus_req_d;
      dbuf_q       <= dbuf_d;
      ibuf_q       <= ibuf_d;
      dbuf_valid_q <= dbuf_valid_d;
      ibuf_valid_q <= ibuf_valid_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_q.we;
  assign bus_sel_o   = bus_q.sel;
  assign bus_addr_o  = bus_q.addr;
  assign bus_wdata_o = bus_q.wdata;

  // Ack-cycle bypass lets a zero-wait access complete without an extra stall cycle.
  assign mem_rdata_o    = d_ack ? bus_rdata_i : dbuf_q;
  assign if_data_o      = i_ack ? bus_rdata_i : ibuf_q;
  assign mem_stallreq_o = mem_ce_i & ~dbuf_valid_q & ~d_ack;
  assign if_stallreq_o  = if_ce_i & ~ibuf_valid_q & ~(i_ack & ~flush_i);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter: fetch, load/store, priority,
// flush, held results and reset behaviour with hand-computed expectations.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_stallreq_o;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  int tests_run;
  int tests_failed;

  sram_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .if_ce_i        (if_ce_i),
    .if_addr_i      (if_addr_i),
    .if_data_o      (if_data_o),
    .if_stallreq_o  (if_stallreq_o),
    .mem_ce_i       (mem_ce_i),
    .mem_we_i       (mem_we_i),
    .mem_sel_i      (mem_sel_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_stallreq_o (mem_stallreq_o),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_sel_o      (bus_sel_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are then driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_ce_i = 0; if_addr_i = 0; mem_ce_i = 0; mem_we_i = 0; mem_sel_i = 0;
    mem_addr_i = 0; mem_wdata_i = 0; stall_i = 0; flush_i = 0;
    bus_rdata_i = 0; bus_ack_i = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    step();
    step();
    #1;
    tests_run++;
    if ({bus_req_o, bus_we_o, bus_sel_o} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: req/we/sel=%b expected 0", {bus_req_o, bus_we_o, bus_sel_o});
    end
    tests_run++;
    if ({bus_addr_o, bus_wdata_o} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: addr=%h wdata=%h expected 0", bus_addr_o, bus_wdata_o);
    end
    tests_run++;
    if ({if_data_o, mem_rdata_o, if_stallreq_o, mem_stallreq_o} !== 66'h0) begin
      tests_failed++;
      $display("FAIL reset_req_side: if_data=%h mem_rdata=%h stallreqs=%b%b expected 0",
               if_data_o, mem_rdata_o, if_stallreq_o, mem_stallreq_o);
    end
    rst = 0;
    step();
  endtask

  task automatic test_zero_wait_fetch();
    if_ce_i = 1; if_addr_i = 32'h0000_0010;
    #1;
    tests_run++;
    if (if_stallreq_o !== 1'b1 || bus_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL zw_req_cycle: stallreq=%b req=%b expected 1 0", if_stallreq_o, bus_req_o);
    end
    step();
    bus_ack_i = 1; bus_rdata_i = 32'h3C01_0101;
    #1;
    tests_run++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h10) begin
      tests_failed++;
      $display("FAIL zw_bus: req=%b addr=%h expected 1 00000010", bus_req_o, bus_addr_o);
    end
    tests_run++;
    if (if_data_o !== 32'h3C01_0101 || if_stallreq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL zw_ack_cycle: data=%h stallreq=%b expected 3c010101 0", if_data_o, if_stallreq_o);
    end
    step();
    bus_ack_i = 0; bus_rdata_i = 0; if_ce_i = 0;
    #1;
    tests_run++;
    if (bus_req_o !== 1'b0 || if_stallreq_o !== 1'b0 || if_data_o !== 32'h3C01_0101) begin
      tests_failed++;
      $display("FAIL zw_after: req=%b stallreq=%b data=%h expected 0 0 3c010101",
               bus_req_o, if_stallreq_o, if_data_o);
    end
    step();
    step();
  endtask

  task automatic test_simultaneous();
    if_ce_i = 1; if_addr_i = 32'h20;
    mem_ce_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h100;
    #1;
    tests_run++;
    if (mem_stallreq_o !== 1'b1 || if_stallreq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL sim_stall0: mem=%b if=%b expected 1 1", mem_stallreq_o, if_stallreq_o);
    end
    step();
    #1;
    tests_run++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h100 || bus_we_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL sim_data_first: req=%b addr=%h we=%b expected 1 00000100 0",
               bus_req_o, bus_addr_o, bus_we_o);
    end
    step();
    bus_ack_i = 1; bus_rdata_i = 32'hAAAA_0001; stall_i = 6'b010011;
    #1;
    tests_run++;
    if (mem_rdata_o !== 32'hAAAA_0001 || mem_stallreq_o !== 1'b0 || if_stallreq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL sim_data_ack: rdata=%h mstall=%b istall=%b expected aaaa0001 0 1",
               mem_rdata_o, mem_stallreq_o, if_stallreq_o);
    end
    step();
    bus_ack_i = 0; bus_rdata_i = 32'hFFFF_FFFF;
    #1;
    tests_run++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h20) begin
      tests_failed++;
      $display("FAIL sim_fetch_b2b: req=%b addr=%h expected 1 00000020", bus_req_o, bus_addr_o);
    end
    tests_run++;
    if (mem_rdata_o !== 32'hAAAA_0001 || if_stallreq_o !== 1'b1 || mem_stallreq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL sim_dbuf_held: rdata=%h istall=%b mstall=%b expected aaaa0001 1 0",
               mem_rdata_o, if_stallreq_o, mem_stallreq_o);
    end
    step();
    bus_ack_i = 1; bus_rdata_i = 32'h2402_0005;
    #1;
    tests_run++;
    if (if_data_o !== 32'h2402_0005 || if_stallreq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL sim_fetch_ack: data=%h stall=%b expected 24020005 0", if_data_o, if_stallreq_o);
    end
    step();
    idle_inputs();
    #1;
    tests_run++;
    if (bus_req_o !== 1'b0 || if_data_o !== 32'h2402_0005 || mem_rdata_o !== 32'hAAAA_0001) begin
      tests_failed++;
      $display("FAIL sim_end: req=%b idata=%h mdata=%h expected 0 24020005 aaaa0001",
               bus_req_o, if_data_o, mem_rdata_o);
    end
    step();
    step();
  endtask

  task automatic test_store();
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h200; mem_wdata_i = 32'hDEAD_BEEF;
    step();
    // Wiggle the requester inputs to prove the issued fields do not follow them.
    mem_addr_i = 32'h999; mem_wdata_i = 32'h0; mem_sel_i = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, mem_stallreq_o} !==
          {1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF, 1'b1}) begin
        tests_failed++;
        $display("FAIL store_wait%0d: req=%b we=%b sel=%b addr=%h wdata=%h stall=%b expected 1 1 0011 00000200 deadbeef 1",
                 c, bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, mem_stallreq_o);
      end
      step();
    end
    bus_ack_i = 1; bus_rdata_i = 32'h0;
    #1;
    tests_run++;
    if (mem_stallreq_o !== 1'b0 || bus_addr_o !== 32'h200) begin
      tests_failed++;
      $display("FAIL store_ack: stall=%b addr=%h expected 0 00000200", mem_stallreq_o, bus_addr_o);
    end
    step();
    idle_inputs();
    #1;
    tests_run++;
    if (bus_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_done: req=%b expected 0", bus_req_o);
    end
    step();
    step();
  endtask

  task automatic test_flush_fetch();
    if_ce_i = 1; if_addr_i = 32'h40;
    step();
    step();
    flush_i = 1;
    #1;
    tests_run++;
    if (bus_req_o !== 1'b1 || if_stallreq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_cycle: req=%b stall=%b expected 1 1", bus_req_o, if_stallreq_o);
    end
    step();
    flush_i = 0;
    #1;
    tests_run++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h40) begin
      tests_failed++;
      $display("FAIL flush_held: req=%b addr=%h expected 1 00000040", bus_req_o, bus_addr_o);
    end
    step();
    bus_ack_i = 1; bus_rdata_i = 32'hBADB_AD00;
    #1;
    tests_run++;
    if (if_data_o !== 32'h2402_0005 || if_stallreq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_ack_drop: data=%h stall=%b expected 24020005 1", if_data_o, if_stallreq_o);
    end
    step();
    bus_ack_i = 0; bus_rdata_i = 0;
    #1;
    tests_run++;
    if (bus_req_o !== 1'b0 || if_data_o !== 32'h2402_0005 || if_stallreq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_after: req=%b data=%h stall=%b expected 0 24020005 1",
               bus_req_o, if_data_o, if_stallreq_o);
    end
    if_ce_i = 0;
    step();
    step();
  endtask

  task automatic test_held_result();
    mem_ce_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h300;
    step();
    bus_ack_i = 1; bus_rdata_i = 32'h1234_5678; stall_i = 6'b011111;
    #1;
    tests_run++;
    if (mem_rdata_o !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL held_ack: rdata=%h expected 12345678", mem_rdata_o);
    end
    step();
    bus_ack_i = 0; bus_rdata_i = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (mem_rdata_o !== 32'h1234_5678 || bus_req_o !== 1'b0 || mem_stallreq_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL held_stall%0d: rdata=%h req=%b stall=%b expected 12345678 0 0",
                 c, mem_rdata_o, bus_req_o, mem_stallreq_o);
      end
      step();
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_reset_dbusy();
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'hF; mem_addr_i = 32'h400; mem_wdata_i = 32'h55;
    step();
    #1;
    tests_run++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h400) begin
      tests_failed++;
      $display("FAIL rstd_issue: req=%b addr=%h expected 1 00000400", bus_req_o, bus_addr_o);
    end
    rst = 1;
    idle_inputs();
    step();
    #1;
    tests_run++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !== 70'h0 ||
        {if_data_o, mem_rdata_o} !== 64'h0) begin
      tests_failed++;
      $display("FAIL rstd_outputs: req=%b we=%b sel=%b addr=%h wdata=%h idata=%h mdata=%h expected all 0",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, if_data_o, mem_rdata_o);
    end
    rst = 0;
    step();
    bus_ack_i = 1; bus_rdata_i = 32'h7777_7777;
    #1;
    tests_run++;
    if (mem_rdata_o !== 32'h0 || if_data_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL idle_ack_ignored: mdata=%h idata=%h expected 0 0", mem_rdata_o, if_data_o);
    end
    step();
    bus_ack_i = 0; bus_rdata_i = 0; if_ce_i = 1; if_addr_i = 32'h50;
    step();
    bus_ack_i = 1; bus_rdata_i = 32'h11;
    #1;
    tests_run++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h50 || if_data_o !== 32'h11) begin
      tests_failed++;
      $display("FAIL rstd_idle_fetch: req=%b addr=%h data=%h expected 1 00000050 00000011",
               bus_req_o, bus_addr_o, if_data_o);
    end
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_zero_wait_fetch();
    test_simultaneous();
    test_store();
    test_flush_fetch();
    test_held_result();
    test_reset_dbusy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
